// File: rtl/aes_tcdm_arbiter.sv
// rtl/aes_tcdm_arbiter.sv - round-robin share of one TCDM master port among N_REQ AES streamers
// In-order responses are routed back through a FIFO of granted requester indices.
module aes_tcdm_arbiter #(
  parameter int N_REQ       = 2,
  parameter int OUTSTANDING = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        in_req_i,
  output logic [N_REQ-1:0]        in_gnt_o,
  input  logic [N_REQ*AW-1:0]     in_add_i,
  input  logic [N_REQ-1:0]        in_wen_i,
  input  logic [N_REQ*DW/8-1:0]   in_be_i,
  input  logic [N_REQ*DW-1:0]     in_data_i,
  output logic [N_REQ*DW-1:0]     in_r_data_o,
  output logic [N_REQ-1:0]        in_r_valid_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [AW-1:0]           tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DW/8-1:0]         tcdm_be_o,
  output logic [DW-1:0]           tcdm_data_o,
  input  logic [DW-1:0]           tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int BW = DW / 8;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FW = $clog2(OUTSTANDING);
  localparam int CW = FW + 1;

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_fifo [OUTSTANDING];
  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_found_hi;
  logic          w_found;
  logic [PW-1:0] w_sel_hi;
  logic [PW-1:0] w_sel_lo;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_head;
  logic          w_accept;
  logic          w_pop;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_found    = 1'b0;
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in_req_i[i]) begin
        w_found  = 1'b1;
        w_sel_lo = PW'(i);
        if (PW'(i) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_sel_hi   = PW'(i);
        end
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
  end

  assign w_head     = r_fifo[r_rd_ptr];
  assign tcdm_req_o = w_found && (r_cnt != CW'(OUTSTANDING));
  assign w_accept   = tcdm_req_o && tcdm_gnt_i;
  assign w_pop      = tcdm_r_valid_i && (r_cnt != '0);
  assign busy_o     = (r_cnt != '0);
  assign err_o      = r_err;
  assign in_r_data_o = {N_REQ{tcdm_r_data_i}};

  always_comb begin
    tcdm_add_o   = '0;
    tcdm_wen_o   = 1'b0;
    tcdm_be_o    = '0;
    tcdm_data_o  = '0;
    in_gnt_o     = '0;
    in_r_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_found && (w_sel == PW'(i))) begin
        tcdm_add_o  = in_add_i[i*AW +: AW];
        tcdm_wen_o  = in_wen_i[i];
        tcdm_be_o   = in_be_i[i*BW +: BW];
        tcdm_data_o = in_data_i[i*DW +: DW];
        in_gnt_o[i] = w_accept;
      end
      in_r_valid_o[i] = w_pop && (w_head == PW'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_sel == PW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_accept && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // A response with nothing outstanding is dropped and flagged until reset.
      if (tcdm_r_valid_i && (r_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

endmodule
